// File: rtl/reg_file.sv
// 8 x 16-bit register file: two registered read ports (A, B), one write port (D), gated by I_en.
// Latency: 1 cycle from select to O_dataA/O_dataB. There is no backpressure; I_en=0 freezes all state.
// Optional macro REG_FILE_BYPASS_EN forwards same-edge write data to the read ports.
module reg_file #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              I_clk,
   input  logic              I_rst_n,
   input  logic              I_en,
   input  logic              I_we,
   input  logic [ADDR_W-1:0] I_selA,
   input  logic [ADDR_W-1:0] I_selB,
   input  logic [ADDR_W-1:0] I_selD,
   input  logic [DATA_W-1:0] I_dataD,
   output logic [DATA_W-1:0] O_dataA,
   output logic [DATA_W-1:0] O_dataB
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] rdA;
   logic [DATA_W-1:0] rdB;
   logic              wrEn;

   assign wrEn = I_en & I_we;

`ifdef REG_FILE_BYPASS_EN
   // Forward the incoming write so a same-edge read sees the new value.
   assign rdA = (I_we && (I_selA == I_selD)) ? I_dataD : regs[I_selA];
   assign rdB = (I_we && (I_selB == I_selD)) ? I_dataD : regs[I_selB];
`else
   assign rdA = regs[I_selA];
   assign rdB = regs[I_selB];
`endif

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wrEn) begin
         regs[I_selD] <= I_dataD;
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         O_dataA <= '0;
         O_dataB <= '0;
      end else if (I_en) begin
         O_dataA <= rdA;
         O_dataB <= rdB;
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Testbench for reg_file: directed steps followed by random traffic, checked against an array model.
module tb_reg_file;

   logic        I_clk = 1'b0;
   logic        I_rst_n;
   logic        I_en;
   logic        I_we;
   logic [2:0]  I_selA;
   logic [2:0]  I_selB;
   logic [2:0]  I_selD;
   logic [15:0] I_dataD;
   logic [15:0] O_dataA;
   logic [15:0] O_dataB;

   int testsRun = 0;
   int testsFailed = 0;

   logic [15:0] mdl [8];
   logic [15:0] expA;
   logic [15:0] expB;

   reg_file #(.DATA_W(16), .ADDR_W(3)) dut (
      .I_clk   (I_clk),
      .I_rst_n (I_rst_n),
      .I_en    (I_en),
      .I_we    (I_we),
      .I_selA  (I_selA),
      .I_selB  (I_selB),
      .I_selD  (I_selD),
      .I_dataD (I_dataD),
      .O_dataA (O_dataA),
      .O_dataB (O_dataB)
   );

   always #5 I_clk = ~I_clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive at the negedge, let one rising edge happen, update the model, then check at the next negedge.
   task automatic step(input logic en, input logic we, input logic [2:0] sA, input logic [2:0] sB,
                       input logic [2:0] sD, input logic [15:0] d, input string tag);
      I_en = en; I_we = we; I_selA = sA; I_selB = sB; I_selD = sD; I_dataD = d;
      @(posedge I_clk);
      if (en) begin
`ifdef REG_FILE_BYPASS_EN
         expA = (we && sA == sD) ? d : mdl[sA];
         expB = (we && sB == sD) ? d : mdl[sB];
`else
         expA = mdl[sA];
         expB = mdl[sB];
`endif
         if (we) mdl[sD] = d;
      end
      @(negedge I_clk);
      chk({tag, ".A"}, O_dataA, expA);
      chk({tag, ".B"}, O_dataB, expB);
   endtask

   task automatic modelReset();
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
      expA = 16'h0000;
      expB = 16'h0000;
   endtask

   initial begin
      I_rst_n = 1'b0; I_en = 1'b0; I_we = 1'b0;
      I_selA = '0; I_selB = '0; I_selD = '0; I_dataD = '0;
      modelReset();
      #2;
      chk("reset.A", O_dataA, 16'h0000);
      chk("reset.B", O_dataB, 16'h0000);
      @(negedge I_clk);
      @(negedge I_clk);
      I_rst_n = 1'b1;
      @(negedge I_clk);

      // Every register reads zero out of reset.
      for (int i = 0; i < 4; i++) step(1, 0, 3'(i), 3'(i + 4), 3'd0, 16'h0, "rstRead");

      // r0 is writable.
      step(1, 1, 3'd0, 3'd1, 3'd0, 16'hFFFF, "r0wr");
      step(1, 0, 3'd0, 3'd1, 3'd0, 16'h0000, "r0rd");
      chk("r0.A", O_dataA, 16'hFFFF);
      chk("r0.B", O_dataB, 16'h0000);

      // Write inhibit, then write, then overwrite.
      for (int i = 0; i < 3; i++) step(1, 0, 3'd2, 3'd2, 3'd2, 16'h2222, "inhibit");
      chk("inhibit.r2", O_dataA, 16'h0000);
      step(1, 1, 3'd3, 3'd3, 3'd2, 16'h2222, "r2wr");
      step(1, 0, 3'd2, 3'd2, 3'd2, 16'h2222, "r2rd");
      chk("r2.2222", O_dataA, 16'h2222);
      step(1, 1, 3'd3, 3'd3, 3'd2, 16'h3333, "r2wr2");
      step(1, 0, 3'd2, 3'd0, 3'd2, 16'h0000, "r2rd2");
      chk("r2.3333", O_dataA, 16'h3333);

      // Enable gating freezes outputs and blocks writes.
      step(0, 1, 3'd4, 3'd5, 3'd4, 16'h4444, "gate0");
      step(0, 1, 3'd6, 3'd7, 3'd4, 16'h4444, "gate1");
      chk("gate.frozenA", O_dataA, 16'h3333);
      step(1, 0, 3'd4, 3'd4, 3'd4, 16'h0000, "gateRd");
      chk("gate.r4held", O_dataA, 16'h0000);
      step(1, 1, 3'd0, 3'd0, 3'd4, 16'h4444, "r4wr");
      step(1, 0, 3'd4, 3'd4, 3'd0, 16'h0000, "r4rd");
      chk("r4.A", O_dataA, 16'h4444);
      chk("r4.B", O_dataB, 16'h4444);

      // Same-address read and write on one edge.
      step(1, 1, 3'd0, 3'd0, 3'd5, 16'h1234, "r5init");
      step(1, 1, 3'd5, 3'd5, 3'd5, 16'hABCD, "r5same");
`ifdef REG_FILE_BYPASS_EN
      chk("sameAddr", O_dataA, 16'hABCD);
`else
      chk("sameAddr", O_dataA, 16'h1234);
`endif
      step(1, 0, 3'd5, 3'd0, 3'd0, 16'h0000, "r5after");
      chk("sameAddr.after", O_dataA, 16'hABCD);

      // Sweep: write all registers, then read every A/B pair.
      for (int i = 0; i < 8; i++) step(1, 1, 3'd0, 3'd0, 3'(i), 16'(16'h1111 * (i + 1)), "sweepWr");
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++) step(1, 0, 3'(a), 3'(b), 3'd0, 16'h0000, "sweepRd");
      chk("sweep.r7", O_dataA, 16'h8888);

      // Random traffic.
      for (int n = 0; n < 400; n++)
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), 3'($urandom),
              3'($urandom), 16'($urandom), "rand");

      // Mid-cycle reset clears outputs without a clock edge.
      step(1, 0, 3'd7, 3'd6, 3'd0, 16'h0000, "preRst");
      @(posedge I_clk);
      #2;
      I_rst_n = 1'b0;
      #1;
      modelReset();
      chk("midRst.A", O_dataA, 16'h0000);
      chk("midRst.B", O_dataB, 16'h0000);
      @(negedge I_clk);
      I_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(1, 0, 3'(i), 3'(7 - i), 3'd0, 16'h0, "postRst");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
